// File: rtl/tile_pkg.sv
// tile_pkg: shared lane/lives constants, judge state type and press helper
package tile_pkg;
   localparam int NUM_LANES = 4;
   localparam int LIVES_W = 2;
   typedef logic [1:0] lane_t;
   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_LOCKED, ST_OVER} judge_state_t;
   function automatic logic single_press(input logic [NUM_LANES-1:0] p);
      return (p != '0) && ((p & (p - 1'b1)) == '0);
   endfunction
endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises one active-low key, optionally debounces it (TILE_HIT_JUDGE_DEBOUNCE_EN), flags press edges
module key_conditioner
   import tile_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic press
);
   logic sync_1, sync_2, cond, cond_d;
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   // two-flop synchroniser, idling at the released level
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
      end
`ifdef TILE_HIT_JUDGE_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   // adopt a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         cond <= 1'b1;
         cnt <= '0;
      end else if (sync_2 == cond) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cond <= sync_2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
`else
   assign cond = sync_2;
`endif
   // previous conditioned level, used to find the 1->0 press edge
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) cond_d <= 1'b1;
      else cond_d <= cond;
   assign press = cond_d & ~cond;
endmodule

// File: rtl/tile_hit_judge.sv
// tile_hit_judge: judges lane presses against the bottom-row tile; debounce via TILE_HIT_JUDGE_DEBOUNCE_EN
module tile_hit_judge
   import tile_pkg::*;
#(
   parameter int LIVES = 3,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 startn,
   input  logic [NUM_LANES-1:0] keys_n,
   input  logic                 tile_valid,
   input  lane_t                tile_lane,
   input  logic                 row_advance,
   output logic                 increment,
   output logic                 miss,
   output logic [LIVES_W-1:0]   lives,
   output logic                 playing,
   output logic                 game_over
);
   judge_state_t state, state_nx;
   logic [NUM_LANES-1:0] press;
   logic [LIVES_W-1:0] lives_nx;
   logic inc_nx, miss_nx, hit, penal;
   if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
      $error("LIVES must be in 1..3");
   end
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .clock  (clock),
         .resetn (resetn),
         .key_n  (keys_n[i]),
         .press  (press[i])
      );
   end
   assign hit = single_press(press) && tile_valid && press[tile_lane];
   assign penal = !hit && ((press != '0) || (row_advance && tile_valid));
   // next state and next registered outputs; a hit wins over a same-cycle advance
   always_comb begin
      state_nx = state;
      inc_nx = 1'b0;
      miss_nx = 1'b0;
      lives_nx = lives;
      case (state)
         ST_IDLE, ST_OVER: if (!startn) begin
            state_nx = ST_PLAY;
            lives_nx = LIVES_W'(LIVES);
         end
         ST_PLAY: if (hit) begin
            inc_nx = 1'b1;
            state_nx = row_advance ? ST_PLAY : ST_LOCKED;
         end else if (penal) begin
            miss_nx = 1'b1;
            lives_nx = (lives == '0) ? '0 : lives - 1'b1;
            state_nx = (lives <= LIVES_W'(1)) ? ST_OVER : ST_PLAY;
         end
         ST_LOCKED: if (row_advance) state_nx = ST_PLAY;
         default: state_nx = ST_IDLE;
      endcase
   end
   // state and all outputs registered together
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state <= ST_IDLE;
         increment <= 1'b0;
         miss <= 1'b0;
         lives <= '0;
         playing <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state <= state_nx;
         increment <= inc_nx;
         miss <= miss_nx;
         lives <= lives_nx;
         playing <= (state_nx == ST_PLAY) || (state_nx == ST_LOCKED);
         game_over <= state_nx == ST_OVER;
      end
endmodule

// File: tb/tb_tile_hit_judge.sv
// tb_tile_hit_judge: directed scoreboard bench for tile_hit_judge
module tb_tile_hit_judge;
   localparam logic [1:0] EV_NONE = 2'd0, EV_INC = 2'd1, EV_MISS = 2'd2;
   logic clock = 1'b0, resetn = 1'b0, startn = 1'b1;
   logic [3:0] keys_n = 4'hF;
   logic tile_valid = 1'b0, row_advance = 1'b0;
   logic [1:0] tile_lane = 2'd0;
   logic increment, miss, playing, game_over;
   logic [1:0] lives;
   logic [1:0] exp_q[$];
   int compared = 0, mismatched = 0;

   tile_hit_judge dut (
      .clock       (clock),
      .resetn      (resetn),
      .startn      (startn),
      .keys_n      (keys_n),
      .tile_valid  (tile_valid),
      .tile_lane   (tile_lane),
      .row_advance (row_advance),
      .increment   (increment),
      .miss        (miss),
      .lives       (lives),
      .playing     (playing),
      .game_over   (game_over)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic start_game();
      startn = 1'b0;
      cyc(1);
      startn = 1'b1;
   endtask

   // every pulse seen must match the oldest expected event
   always @(negedge clock) begin
      if (increment === 1'b1 && miss === 1'b1) check("inc_miss_overlap", 8'd1, 8'd0);
      else if (increment === 1'b1 || miss === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_pulse", {6'd0, increment ? EV_INC : EV_MISS}, {6'd0, EV_NONE});
         else check("pulse_kind", {6'd0, increment ? EV_INC : EV_MISS}, {6'd0, exp_q.pop_front()});
      end
   end

   initial begin
      cyc(3);
      check("rst_increment", {7'd0, increment}, 8'd0);
      check("rst_miss", {7'd0, miss}, 8'd0);
      check("rst_lives", {6'd0, lives}, 8'd0);
      check("rst_playing", {7'd0, playing}, 8'd0);
      check("rst_game_over", {7'd0, game_over}, 8'd0);
      resetn = 1'b1;
      cyc(2);
      start_game();
      check("start_playing", {7'd0, playing}, 8'd1);
      check("start_lives", {6'd0, lives}, 8'd3);
      check("start_game_over", {7'd0, game_over}, 8'd0);
      // correct hit on lane 2, with exact latency
      tile_valid = 1'b1;
      tile_lane = 2'd2;
      keys_n = 4'b1011;
      exp_q.push_back(EV_INC);
      cyc(1);
      check("lat_n", {7'd0, increment}, 8'd0);
      cyc(1);
      check("lat_n1", {7'd0, increment}, 8'd0);
      cyc(1);
      check("lat_n2", {7'd0, increment}, 8'd1);
      cyc(1);
      check("lat_n3", {7'd0, increment}, 8'd0);
      check("hit_lives", {6'd0, lives}, 8'd3);
      keys_n = 4'hF;
      cyc(3);
      // LOCKED ignores a wrong press
      keys_n = 4'b1110;
      cyc(5);
      keys_n = 4'hF;
      cyc(3);
      check("locked_lives", {6'd0, lives}, 8'd3);
      row_advance = 1'b1;
      cyc(1);
      row_advance = 1'b0;
      cyc(2);
      check("unlock_no_miss_lives", {6'd0, lives}, 8'd3);
      // wrong lane
      tile_lane = 2'd1;
      keys_n = 4'b0111;
      exp_q.push_back(EV_MISS);
      cyc(4);
      check("wrong_lane_lives", {6'd0, lives}, 8'd2);
      keys_n = 4'hF;
      cyc(3);
      // correct hit on the same edge as row_advance stays in PLAY
      tile_lane = 2'd0;
      keys_n = 4'b1110;
      exp_q.push_back(EV_INC);
      cyc(2);
      row_advance = 1'b1;
      cyc(1);
      row_advance = 1'b0;
      cyc(2);
      check("hit_adv_lives", {6'd0, lives}, 8'd2);
      keys_n = 4'hF;
      cyc(3);
      tile_lane = 2'd3;
      keys_n = 4'b0111;
      exp_q.push_back(EV_INC);
      cyc(4);
      keys_n = 4'hF;
      cyc(3);
      row_advance = 1'b1;
      cyc(1);
      row_advance = 1'b0;
      cyc(2);
      // two lanes at once, then held for 100 cycles
      keys_n = 4'b1100;
      exp_q.push_back(EV_MISS);
      cyc(100);
      check("double_lives", {6'd0, lives}, 8'd1);
      keys_n = 4'hF;
      cyc(3);
      // wrong press plus unhit advance: one miss, last life gone
      tile_lane = 2'd0;
      keys_n = 4'b1011;
      exp_q.push_back(EV_MISS);
      cyc(2);
      row_advance = 1'b1;
      cyc(1);
      row_advance = 1'b0;
      cyc(3);
      check("over_lives", {6'd0, lives}, 8'd0);
      check("over_game_over", {7'd0, game_over}, 8'd1);
      check("over_playing", {7'd0, playing}, 8'd0);
      keys_n = 4'hF;
      cyc(3);
      // restart, then three unhit advances
      start_game();
      check("restart_lives", {6'd0, lives}, 8'd3);
      check("restart_game_over", {7'd0, game_over}, 8'd0);
      tile_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(EV_MISS);
         row_advance = 1'b1;
         cyc(1);
         row_advance = 1'b0;
         cyc(2);
      end
      check("adv3_lives", {6'd0, lives}, 8'd0);
      check("adv3_game_over", {7'd0, game_over}, 8'd1);
      keys_n = 4'b1110;
      row_advance = 1'b1;
      cyc(1);
      row_advance = 1'b0;
      cyc(5);
      keys_n = 4'hF;
      cyc(3);
      check("over_quiet_lives", {6'd0, lives}, 8'd0);
      // reset during LOCKED with a press pending
      start_game();
      tile_lane = 2'd1;
      keys_n = 4'b1101;
      exp_q.push_back(EV_INC);
      cyc(4);
      keys_n = 4'hF;
      cyc(3);
      keys_n = 4'b1110;
      cyc(2);
      resetn = 1'b0;
      #1;
      check("mid_rst_increment", {7'd0, increment}, 8'd0);
      check("mid_rst_miss", {7'd0, miss}, 8'd0);
      check("mid_rst_lives", {6'd0, lives}, 8'd0);
      check("mid_rst_playing", {7'd0, playing}, 8'd0);
      check("mid_rst_game_over", {7'd0, game_over}, 8'd0);
      cyc(2);
      resetn = 1'b1;
      cyc(2);
      check("idle_playing", {7'd0, playing}, 8'd0);
      start_game();
      check("post_rst_playing", {7'd0, playing}, 8'd1);
      check("post_rst_lives", {6'd0, lives}, 8'd3);
      cyc(5);
      keys_n = 4'hF;
      cyc(5);
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/tile_hit_judge.md
TILE_HIT_JUDGE -- requirements
Module: tile_hit_judge

Interface
REQ-001 Parameter: LIVES, default 3, lives loaded at game start (1..3).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 50000, stable-sample count per key (used only with the debounce macro).
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: resetn  in  1  reset, asynchronous, active-low.
REQ-005 Port: startn  in  1  active-low start request, synchronous level.
REQ-006 Port: keys_n  in  4  active-low lane buttons, asynchronous; bit i = lane i.
REQ-007 Port: tile_valid  in  1  bottom row currently holds a tile.
REQ-008 Port: tile_lane  in  2  lane index of the bottom-row tile; meaningful only while tile_valid=1.
REQ-009 Port: row_advance  in  1  one-cycle pulse when the tile field scrolls one row.
REQ-010 Port: increment  out  1  one-cycle pulse per correct hit, for the score counter.
REQ-011 Port: miss  out  1  one-cycle pulse per penalised event.
REQ-012 Port: lives  out  2  remaining lives.
REQ-013 Port: playing  out  1  high in PLAY or LOCKED.
REQ-014 Port: game_over  out  1  high in OVER.

Function
REQ-015 Each keys_n bit shall pass through a 2-flop synchroniser, then a press-edge detector; a press event is the 1->0 transition of the conditioned key.
REQ-016 FSM states: IDLE, PLAY, LOCKED, OVER; all outputs shall be registered.
REQ-017 IDLE or OVER with startn=0: go to PLAY, load lives=LIVES, clear game_over.
REQ-018 PLAY: press event on exactly one lane, tile_valid=1, lane==tile_lane: pulse increment, go to LOCKED.
REQ-019 PLAY: press event on a wrong lane, with tile_valid=0, or on two or more lanes in the same cycle: one miss pulse, lives-1.
REQ-020 PLAY: row_advance with tile_valid=1 (tile not hit): one miss pulse, lives-1.
REQ-021 LOCKED: ignore all press events; on row_advance return to PLAY without a miss.
REQ-022 Same-cycle correct hit and row_advance in PLAY: judge against pre-advance tile_lane, pulse increment, next state PLAY.
REQ-023 Same-cycle wrong press and unhit row_advance: exactly one miss, lives decrements by 1 only.
REQ-024 When a miss takes lives to 0: go to OVER, game_over=1 on the same edge; lives saturates at 0.
REQ-025 increment and miss shall never be high in the same cycle; each is high for exactly one cycle per event.
REQ-026 Latency without debounce: for a key first sampled low at edge N, increment/miss is high after edge N+2 and low after edge N+3.
REQ-027 Key held low: one press event only; the next event requires release and re-press.
REQ-028 IDLE/OVER: presses, tile_valid and row_advance produce no pulses.

Reset
REQ-029 resetn=0 shall asynchronously force: state IDLE, increment=0, miss=0, lives=0, playing=0, game_over=0, synchroniser and debounce flops to released (1)/0 count.
REQ-030 Reset mid-game shall discard any pending press event; after release, no pulse until a new press in PLAY.

Configuration
REQ-031 Macro TILE_HIT_JUDGE_DEBOUNCE_EN defined: a synchronised key changes conditioned state only after DEBOUNCE_CYCLES consecutive equal samples; latency becomes N+2+DEBOUNCE_CYCLES.
REQ-032 Macro absent: no debounce logic; the synchronised key is the conditioned key; REQ-026 latency applies.

Structure
REQ-033 Shared package tile_pkg: NUM_LANES=4, lane index typedef (2 bits), judge state enum, lives width constant.
REQ-034 One sub-module key_conditioner (synchroniser, optional debounce, press-edge detect), instantiated once per lane.

Verification
REQ-035 Start, tile_lane=2, tile_valid=1, press lane 2 -> one increment at N+2, state LOCKED, lives=3.
REQ-036 PLAY, tile_lane=1, press lane 3 -> one miss, lives 3->2, no increment.
REQ-037 Three unhit row_advance pulses with tile_valid=1 -> three misses, lives=0, game_over=1, later presses give no pulses.
REQ-038 Correct press on the same edge as row_advance -> increment only, state PLAY, lives unchanged.
REQ-039 Lanes 0 and 1 pressed on the same sample -> exactly one miss; key held 100 cycles -> no further pulses.
REQ-040 resetn low during LOCKED -> all outputs 0, state IDLE; startn=0 -> playing=1, lives=3.
